// File: rtl/apu_sfx_pkg.sv
// Shared types and constants for apu_sfx_scheduler: FSM states, effect ids,
// the per-effect note table and the request arbitration helpers.
package apu_sfx_pkg;

    localparam int unsigned NOTE_W  = 9;
    localparam int unsigned N_SFX   = 3;
    localparam int unsigned N_STEPS = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned STEP_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [ID_W-1:0] SFX_PLAYER_HIT = 2'd0;
    localparam logic [ID_W-1:0] SFX_SWORD_HIT  = 2'd1;
    localparam logic [ID_W-1:0] SFX_SHEEP      = 2'd2;

    // Half-periods in line_tick units; 0 is a rest step.
    localparam logic [NOTE_W-1:0] NOTE_TABLE [N_SFX][N_STEPS] = '{
        '{9'd64, 9'd80, 9'd107, 9'd143},
        '{9'd48, 9'd40, 9'd32,  9'd27 },
        '{9'd36, 9'd0,  9'd36,  9'd54 }
    };

    function automatic logic [NOTE_W-1:0] note_hp(input logic [ID_W-1:0]   id,
                                                  input logic [STEP_W-1:0] step);
        logic [NOTE_W-1:0] hp;
        hp = '0;
        case (id)
            SFX_PLAYER_HIT: hp = NOTE_TABLE[0][step];
            SFX_SWORD_HIT:  hp = NOTE_TABLE[1][step];
            SFX_SHEEP:      hp = NOTE_TABLE[2][step];
            default:        hp = '0;
        endcase
        return hp;
    endfunction

    // Fixed priority: the lowest set index wins.
    function automatic logic [ID_W-1:0] pick_winner(input logic [N_SFX-1:0] pend);
        logic [ID_W-1:0] w;
        w = SFX_SHEEP;
        if (pend[1]) w = SFX_SWORD_HIT;
        if (pend[0]) w = SFX_PLAYER_HIT;
        return w;
    endfunction

    // Request bits that outrank the given effect.
    function automatic logic [N_SFX-1:0] higher_prio_mask(input logic [ID_W-1:0] id);
        logic [N_SFX-1:0] m;
        case (id)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/apu_sfx_scheduler_tone_gen.sv
// Square-wave tone generator: counts line ticks up to a half-period and
// toggles its output; a zero half-period holds the output low (rest).
module sfx_tone_gen
    import apu_sfx_pkg::*;
#(
    parameter int unsigned HP_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_tick,
    input  logic [HP_W-1:0] i_half_period,
    output logic            o_tone
);

    logic [HP_W-1:0] r_cnt;
    logic            r_tone;

    // Clear wins over a coincident tick so a new step always starts from phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_tick) begin
            if (i_half_period == '0) begin
                r_cnt  <= '0;
                r_tone <= 1'b0;
            end else if (r_cnt >= i_half_period - HP_W'(1)) begin
                r_cnt  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_cnt <= r_cnt + HP_W'(1);
            end
        end
    end

    assign o_tone = r_tone;

endmodule

// File: rtl/apu_sfx_scheduler.sv
// One-shot sound-effect scheduler sharing the audio pin with BGM: edge-captured
// requests, fixed-priority preemptive arbitration, 4-step note sequences.
// Build option SFX_BGM_MIX_EN: OR the BGM bit into the effect tone instead of muting it.
module apu_sfx_scheduler
    import apu_sfx_pkg::*;
#(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned HP_W        = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frame_tick,
    input  logic             i_line_tick,
    input  logic [N_SFX-1:0] i_sfx_req,
    input  logic             i_bgm_in,
    output logic             o_audio_out,
    output logic             o_sfx_active,
    output logic [ID_W-1:0]  o_sfx_id,
    output logic [N_SFX-1:0] o_pending
);

    localparam int unsigned       FC_W      = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(STEP_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [N_SFX-1:0]   r_req_q;
    logic [N_SFX-1:0]   r_pending;
    logic [ID_W-1:0]    r_sfx_id;
    logic [STEP_W-1:0]  r_step;
    logic [FC_W-1:0]    r_frame_cnt;
    logic               r_sfx_active;

    logic [N_SFX-1:0]   w_rise;
    logic [N_SFX-1:0]   w_clr_mask;
    logic [ID_W-1:0]    w_winner;
    logic               w_preempt;
    logic               w_step_end;
    logic               w_load;
    logic               w_frame_adv;
    logic               w_tone_clear;
    logic               w_tone_tick;
    logic               w_tone;
    logic [HP_W-1:0]    w_half_period;

    assign w_rise     = i_sfx_req & ~r_req_q;
    assign w_winner   = pick_winner(r_pending);
    assign w_preempt  = |(r_pending & higher_prio_mask(r_sfx_id));
    assign w_step_end = i_frame_tick && (r_frame_cnt == FC_LAST);
    assign w_clr_mask = w_load ? (N_SFX'(1) << w_winner) : '0;

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_frame_adv  = 1'b0;
        w_tone_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pending) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_load       = 1'b1;
                w_tone_clear = 1'b1;
                w_state_nxt  = PLAY;
            end
            PLAY: begin
                if (w_preempt) begin
                    w_state_nxt = LOAD;
                end else if (i_frame_tick) begin
                    w_frame_adv = 1'b1;
                    if (w_step_end) begin
                        w_tone_clear = 1'b1;
                        if (r_step == STEP_LAST) w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (i_frame_tick) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sfx_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sfx_active <= (w_state_nxt == PLAY);
        end
    end

    // A new edge re-sets a bit even when LOAD clears it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q   <= '0;
            r_pending <= '0;
        end else begin
            r_req_q   <= i_sfx_req;
            r_pending <= (r_pending & ~w_clr_mask) | w_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sfx_id    <= '0;
            r_step      <= '0;
            r_frame_cnt <= '0;
        end else if (w_load) begin
            r_sfx_id    <= w_winner;
            r_step      <= '0;
            r_frame_cnt <= '0;
        end else if (w_frame_adv) begin
            if (w_step_end) begin
                r_frame_cnt <= '0;
                if (r_step != STEP_LAST) r_step <= r_step + STEP_W'(1);
            end else begin
                r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end
        end
    end

    assign w_half_period = HP_W'(note_hp(r_sfx_id, r_step));
    assign w_tone_tick   = i_line_tick && (r_state == PLAY);

    sfx_tone_gen #(
        .HP_W (HP_W)
    ) u_tone_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_tone_clear),
        .i_tick        (w_tone_tick),
        .i_half_period (w_half_period),
        .o_tone        (w_tone)
    );

`ifdef SFX_BGM_MIX_EN
    assign o_audio_out = (r_state == PLAY) ? (w_tone | i_bgm_in) : i_bgm_in;
`else
    assign o_audio_out = (r_state == PLAY) ? w_tone : i_bgm_in;
`endif

    assign o_sfx_active = r_sfx_active;
    assign o_sfx_id     = r_sfx_id;
    assign o_pending    = r_pending;

endmodule

// File: tb/tb_apu_sfx_scheduler.sv
// Scoreboard bench for apu_sfx_scheduler: stimulus queues the expected effect
// starts, a monitor checks each start, every half-period, rests and BGM pass-through.
`timescale 1ns/1ps
module tb_apu_sfx_scheduler;

    localparam int STEP_FRAMES = 4;
    localparam int FRAME_CYC   = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       line_tick;
    logic [2:0] sfx_req;
    logic       bgm_in;
    logic       audio_out;
    logic       sfx_active;
    logic [1:0] sfx_id;
    logic [2:0] pending;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        int id;
        int pend;
        int frames;
    } exp_t;
    exp_t exp_q[$];

    apu_sfx_scheduler #(
        .STEP_FRAMES (STEP_FRAMES),
        .HP_W        (9)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (frame_tick),
        .i_line_tick  (line_tick),
        .i_sfx_req    (sfx_req),
        .i_bgm_in     (bgm_in),
        .o_audio_out  (audio_out),
        .o_sfx_active (sfx_active),
        .o_sfx_id     (sfx_id),
        .o_pending    (pending)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame every FRAME_CYC cycles, scanline every 2 cycles, aligned at x==0.
    int tick_c = 0;
    initial begin
        frame_tick = 1'b0;
        line_tick  = 1'b0;
        forever begin
            @(posedge clk); #1;
            frame_tick = (tick_c == 0);
            line_tick  = (tick_c % 2 == 0);
            tick_c     = (tick_c + 1) % FRAME_CYC;
        end
    end

    int bgm_c = 0;
    initial begin
        bgm_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            bgm_c = bgm_c + 1;
            if (bgm_c == 7) begin
                bgm_c  = 0;
                bgm_in = ~bgm_in;
            end
        end
    end

    function automatic int exp_hp(input int id, input int step);
        case (id * 4 + step)
            0: return 64;   1: return 80;   2: return 107;  3: return 143;
            4: return 48;   5: return 40;   6: return 32;   7: return 27;
            8: return 36;   9: return 0;    10: return 36;  11: return 54;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input int pend, input int frames);
        exp_t e;
        e.id     = id;
        e.pend   = pend;
        e.frames = frames;
        exp_q.push_back(e);
    endtask

    task automatic wait_active(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (sfx_active !== lvl && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        tests = tests + 1;
        if (sfx_active !== lvl) begin
            errors = errors + 1;
            $display("FAIL %s: timeout after %0d cycles, sfx_active %0b expected %0b",
                     name, n, sfx_active, lvl);
        end
    endtask

    // Advance negedges, counting frame_tick pulses from the current negedge on.
    task automatic count_frames(input int target, input string name);
        int nft;
        int n;
        nft = 0;
        n   = 0;
        while (nft < target && n < 4000) begin
            if (frame_tick) nft = nft + 1;
            if (nft < target) @(negedge clk);
            n = n + 1;
        end
        check(name, nft, target);
    endtask

    // Monitor: effect starts pop the scoreboard; tone edges are timed in line ticks.
    logic mon_prev_act = 1'b0;
    logic mon_prev_ft  = 1'b0;
    logic mon_prev_lt  = 1'b0;
    logic mon_last_aud = 1'b0;
    logic mon_stepchg  = 1'b0;
    int   mon_lt_cnt   = 0;
    int   mon_fcnt     = 0;
    int   mon_step     = 0;
    int   mon_frames   = 0;
    int   mon_id       = 0;
    int   mon_exp_fr   = -1;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (sfx_active && !mon_prev_act) begin
                if (exp_q.size() == 0) begin
                    tests  = tests + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_start: got sfx_id %0d expected no effect (t=%0t)",
                             sfx_id, $time);
                    mon_id     = int'(sfx_id);
                    mon_exp_fr = -1;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("start_id", int'(sfx_id), mon_e.id);
                    check("start_pending", int'(pending), mon_e.pend);
                    mon_id     = mon_e.id;
                    mon_exp_fr = mon_e.frames;
                end
                check("start_audio", int'(audio_out), 0);
                mon_lt_cnt   = 0;
                mon_fcnt     = 0;
                mon_step     = 0;
                mon_frames   = 0;
                mon_last_aud = audio_out;
            end else if (sfx_active && mon_prev_act) begin
                mon_stepchg = 1'b0;
                if (mon_prev_lt) mon_lt_cnt = mon_lt_cnt + 1;
                if (mon_prev_ft) begin
                    mon_frames = mon_frames + 1;
                    mon_fcnt   = mon_fcnt + 1;
                    if (mon_fcnt == STEP_FRAMES) begin
                        mon_fcnt    = 0;
                        mon_step    = mon_step + 1;
                        mon_stepchg = 1'b1;
                    end
                end
                if (mon_stepchg) begin
                    mon_lt_cnt = 0;
                end else if (audio_out != mon_last_aud) begin
                    check("half_period", mon_lt_cnt, exp_hp(mon_id, mon_step));
                    mon_lt_cnt = 0;
                end
                if (exp_hp(mon_id, mon_step) == 0) check("rest_silent", int'(audio_out), 0);
                mon_last_aud = audio_out;
            end else if (!sfx_active && mon_prev_act) begin
                if (mon_prev_ft) mon_frames = mon_frames + 1;
                if (mon_exp_fr >= 0) check("play_frames", mon_frames, mon_exp_fr);
            end
            if (!sfx_active) check("bgm_passthru", int'(audio_out), int'(bgm_in));
            mon_prev_act = sfx_active;
            mon_prev_ft  = frame_tick;
            mon_prev_lt  = line_tick;
        end
    end

    initial begin
        rst_n   = 1'b0;
        sfx_req = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", int'(sfx_active), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_id", int'(sfx_id), 0);
        rst_n = 1'b1;

        // Idle with BGM toggling.
        repeat (400) @(posedge clk);
        #1;
        check("idle_active", int'(sfx_active), 0);
        check("idle_pending", int'(pending), 0);

        // Sword hit, held high: 3-cycle latency, one play only.
        push_exp(1, 0, 16);
        sfx_req = 3'b010;
        @(posedge clk); #1;
        check("lat_pending", int'(pending), 3'b010);
        check("lat_active_c1", int'(sfx_active), 0);
        @(posedge clk); #1;
        check("lat_active_c2", int'(sfx_active), 0);
        @(posedge clk); #1;
        check("lat_active_c3", int'(sfx_active), 1);
        check("lat_id", int'(sfx_id), 1);
        check("lat_pending_cleared", int'(pending), 0);
        wait_active(1'b0, 4000, "s2_end");
        repeat (3 * FRAME_CYC) @(negedge clk);
        check("s2_no_replay", int'(sfx_active), 0);
        check("s2_pending", int'(pending), 0);
        sfx_req = 3'b000;

        // Sheep and player hit together: player first, sheep queued behind it.
        @(posedge clk); #1;
        push_exp(0, 3'b100, 16);
        push_exp(2, 0, 16);
        sfx_req = 3'b101;
        wait_active(1'b1, 10, "s3_start0");
        wait_active(1'b0, 4000, "s3_end0");
        check("s3_pending_gap", int'(pending), 3'b100);
        wait_active(1'b1, 2 * FRAME_CYC, "s3_start2");
        sfx_req = 3'b000;
        wait_active(1'b0, 4000, "s3_end2");
        repeat (2 * FRAME_CYC) @(negedge clk);

        // Sheep preempted during its rest step by a player hit.
        @(posedge clk); #1;
        push_exp(2, 0, 5);
        sfx_req = 3'b100;
        wait_active(1'b1, 10, "s4_start2");
        count_frames(5, "s4_frames_seen");
        repeat (20) @(posedge clk);
        #1;
        push_exp(0, 0, 16);
        sfx_req = 3'b001;
        @(posedge clk); #1;
        sfx_req = 3'b000;
        check("s4_pending", int'(pending), 3'b001);
        check("s4_still_playing", int'(sfx_active), 1);
        @(posedge clk); #1;
        check("s4_load", int'(sfx_active), 0);
        @(posedge clk); #1;
        check("s4_replay_active", int'(sfx_active), 1);
        check("s4_replay_id", int'(sfx_id), 0);
        wait_active(1'b0, 4000, "s4_end0");
        repeat (3 * FRAME_CYC) @(negedge clk);
        check("s4_no_sheep_replay", int'(sfx_active), 0);
        check("s4_pending_end", int'(pending), 0);

        // Asynchronous reset in the middle of an effect with a request waiting.
        @(posedge clk); #1;
        push_exp(1, 0, 2);
        sfx_req = 3'b010;
        wait_active(1'b1, 10, "s5_start1");
        count_frames(2, "s5_frames_seen");
        repeat (10) @(posedge clk);
        #1;
        sfx_req = 3'b110;
        @(posedge clk); #1;
        check("s5_low_prio_waits", int'(pending), 3'b100);
        check("s5_id", int'(sfx_id), 1);
        repeat (10) @(posedge clk);
        #3;
        rst_n   = 1'b0;
        sfx_req = 3'b000;
        #1;
        check("s5_rst_active", int'(sfx_active), 0);
        check("s5_rst_pending", int'(pending), 0);
        check("s5_rst_audio", int'(audio_out), int'(bgm_in));
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * FRAME_CYC) @(posedge clk);
        #1;
        check("s5_post_active", int'(sfx_active), 0);
        check("s5_post_pending", int'(pending), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
